// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxfilt_4.sv
// Receive-end conditioner: synchronizes an asynchronous buffered level into CLK,
// rejects runs shorter than FILT_CYCLES and emits one-cycle rise/fall strobes.
module gf180mcu_fd_sc_mcu9t5v0__rxfilt_4 #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYCLES = 4,
   parameter logic RST_VAL     = 1'b0
) (
`ifdef USE_POWER_PINS
   inout  wire  VDD,
   inout  wire  VSS,
`endif
   input  logic CLK,
   input  logic RST,
   input  logic I,
   output logic Z,
   output logic ZR,
   output logic ZF
);

   localparam int CW = $clog2(FILT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("rxfilt: SYNC_STAGES must be >= 2");
   end
   if (FILT_CYCLES < 1) begin : g_bad_filt
      $error("rxfilt: FILT_CYCLES must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   z_q, z_d;
   logic                   zr_q, zr_d;
   logic                   zf_q, zf_d;
   logic                   sy;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], I};
   assign sy     = sync_q[SYNC_STAGES-1];

   // A disagreement run must be contiguous; any matching sample restarts it.
   always_comb begin
      cnt_d = cnt_q;
      z_d   = z_q;
      zr_d  = 1'b0;
      zf_d  = 1'b0;
      if (sy == z_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         z_d   = sy;
         cnt_d = '0;
         zr_d  = sy;
         zf_d  = ~sy;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         cnt_q  <= '0;
         z_q    <= RST_VAL;
         zr_q   <= 1'b0;
         zf_q   <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         z_q    <= z_d;
         zr_q   <= zr_d;
         zf_q   <= zf_d;
      end
   end

   assign Z  = z_q;
   assign ZR = zr_q;
   assign ZF = zf_q;

endmodule
